// File: rtl/ex_dma_loader.sv
// ============================================================================
// Module   : ex_dma_loader
// Brief    : Packs a host byte stream into little-endian 32-bit words and
//            writes them to the data memory external port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_dma_loader #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_byte_cnt,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ex_addr,
  output logic [31:0]       ex_wrt_data,
  output logic              ex_wrt_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PACK  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] c_addr_step = ADDR_W'(4);
  localparam logic [CNT_W-1:0]  c_cnt_one   = CNT_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_word;
  logic [31:0]       w_word_nxt;
  logic [1:0]        r_lane;
  logic              w_xfer;
  logic              w_start_ok;
  logic              w_start_bad;
  logic              w_last_byte;

  assign in_ready    = (r_state == S_PACK);
  assign busy        = (r_state == S_PACK) || (r_state == S_WRITE);
  assign w_xfer      = in_valid && in_ready;
  assign w_start_ok  = (r_state == S_IDLE) && cfg_start && (cfg_base_addr[1:0] == 2'b00);
  assign w_start_bad = (r_state == S_IDLE) && cfg_start && (cfg_base_addr[1:0] != 2'b00);
  // A word closes when its top lane fills or the job runs out of bytes.
  assign w_last_byte = w_xfer && ((r_lane == 2'd3) || (r_cnt == c_cnt_one));

  always_comb begin
    w_word_nxt = r_word;
    if (w_xfer) begin
      w_word_nxt[{r_lane, 3'b000} +: 8] = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok && (cfg_byte_cnt != '0)) begin
          w_state_nxt = S_PACK;
        end
      end
      S_PACK: begin
        if (cfg_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_last_byte) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (cfg_abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_PACK;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_cnt       <= '0;
      r_word      <= '0;
      r_lane      <= '0;
      ex_addr     <= '0;
      ex_wrt_data <= '0;
      ex_wrt_en   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      // Write strobe is registered so it lines up with the WRITE state.
      ex_wrt_en <= (w_state_nxt == S_WRITE);
      done      <= (w_state_nxt == S_DONE) || (w_start_ok && (cfg_byte_cnt == '0));
      err       <= w_start_bad;

      if (w_start_ok && (cfg_byte_cnt != '0)) begin
        r_addr <= cfg_base_addr;
        r_cnt  <= cfg_byte_cnt;
        r_word <= '0;
        r_lane <= '0;
      end

      if (r_state == S_PACK) begin
        if (cfg_abort) begin
          r_word <= '0;
          r_lane <= '0;
        end else if (w_xfer) begin
          r_word <= w_word_nxt;
          r_cnt  <= r_cnt - c_cnt_one;
          r_lane <= r_lane + 2'd1;
        end
        if (w_state_nxt == S_WRITE) begin
          ex_addr     <= r_addr;
          ex_wrt_data <= w_word_nxt;
        end
      end

      if (r_state == S_WRITE) begin
        r_addr <= r_addr + c_addr_step;
        r_word <= '0;
        r_lane <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_dma_loader.sv
// ============================================================================
// Module   : tb_ex_dma_loader
// Brief    : Directed self-checking bench for ex_dma_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_dma_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_abort = 1'b0;
  logic [15:0] cfg_base_addr = '0;
  logic [15:0] cfg_byte_cnt = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic [15:0] ex_addr;
  logic [31:0] ex_wrt_data;
  logic        ex_wrt_en;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [15:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  int          dc_q[$];
  int          err_n = 0;
  logic        busy_seen = 1'b0;

  ex_dma_loader #(.ADDR_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_base_addr(cfg_base_addr), .cfg_byte_cnt(cfg_byte_cnt),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ex_addr(ex_addr), .ex_wrt_data(ex_wrt_data), .ex_wrt_en(ex_wrt_en),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation log, sampled mid-cycle.
  always @(negedge clk) begin
    if (ex_wrt_en) begin
      wa_q.push_back(ex_addr);
      wd_q.push_back(ex_wrt_data);
      wc_q.push_back(cyc);
    end
    if (done) dc_q.push_back(cyc);
    if (err) err_n = err_n + 1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); dc_q.delete();
    err_n = 0; busy_seen = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] base, input logic [15:0] cnt);
    cfg_start = 1'b1; cfg_base_addr = base; cfg_byte_cnt = cnt;
    idle(1);
    cfg_start = 1'b0;
  endtask

  // Holds a byte on the input until the DUT takes it; returns the accept cycle.
  task automatic push_byte(input logic [7:0] b, output int acc_cyc);
    logic acc = 1'b0;
    int   guard = 0;
    acc_cyc = -1;
    in_valid = 1'b1; in_data = b;
    while (!acc && guard < 20) begin
      @(negedge clk);
      acc = in_ready;
      acc_cyc = cyc;
      @(posedge clk); #1;
      guard++;
    end
    if (!acc) begin
      n_checks++; n_errors++;
      $error("FAIL byte_accept observed=timeout expected=accepted byte %0h", b);
    end
    in_valid = 1'b0;
  endtask

  int acc[1:8];
  int a4, a8;

  initial begin
    // Reset state
    idle(3);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrt_en", ex_wrt_en, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", ex_addr, 0);
    chk("rst_data", ex_wrt_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Two full words back-to-back
    clr_mon();
    start_job(16'h0010, 16'd8);
    for (int i = 1; i <= 8; i++) push_byte(8'(i), acc[i]);
    idle(5);
    chk("b2b_nwr", wa_q.size(), 2);
    chk("b2b_a0", wa_q[0], 16'h0010);
    chk("b2b_d0", wd_q[0], 32'h04030201);
    chk("b2b_a1", wa_q[1], 16'h0014);
    chk("b2b_d1", wd_q[1], 32'h08070605);
    chk("b2b_lat0", wc_q[0], acc[4] + 1);
    chk("b2b_lat1", wc_q[1], acc[8] + 1);
    chk("b2b_ndone", dc_q.size(), 1);
    chk("b2b_done_lat", dc_q[0], acc[8] + 2);
    @(negedge clk);
    chk("hold_addr", ex_addr, 16'h0014);
    chk("hold_data", ex_wrt_data, 32'h08070605);
    chk("hold_busy", busy, 0);
    @(posedge clk); #1;

    // Partial final word
    clr_mon();
    start_job(16'h0020, 16'd6);
    for (int i = 1; i <= 6; i++) push_byte(8'(i), acc[i]);
    idle(5);
    chk("part_nwr", wa_q.size(), 2);
    chk("part_a0", wa_q[0], 16'h0020);
    chk("part_d0", wd_q[0], 32'h04030201);
    chk("part_a1", wa_q[1], 16'h0024);
    chk("part_d1", wd_q[1], 32'h00000605);
    chk("part_ndone", dc_q.size(), 1);
    chk("part_done_after_wr", dc_q[0], wc_q[1] + 1);

    // Address wrap
    clr_mon();
    start_job(16'hFFFC, 16'd8);
    for (int i = 1; i <= 8; i++) push_byte(8'h10 + 8'(i), acc[i]);
    idle(5);
    chk("wrap_nwr", wa_q.size(), 2);
    chk("wrap_a0", wa_q[0], 16'hFFFC);
    chk("wrap_d0", wd_q[0], 32'h14131211);
    chk("wrap_a1", wa_q[1], 16'h0000);
    chk("wrap_d1", wd_q[1], 32'h18171615);

    // Misaligned start, then zero-length job
    clr_mon();
    start_job(16'h0002, 16'd4);
    @(negedge clk);
    chk("unal_err", err, 1);
    @(posedge clk); #1;
    idle(3);
    chk("unal_err_once", err_n, 1);
    chk("unal_busy", busy_seen, 0);
    chk("unal_nwr", wa_q.size(), 0);
    chk("unal_ndone", dc_q.size(), 0);
    clr_mon();
    start_job(16'h0030, 16'd0);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(posedge clk); #1;
    idle(3);
    chk("zero_ndone", dc_q.size(), 1);
    chk("zero_nwr", wa_q.size(), 0);
    chk("zero_busy_seen", busy_seen, 0);

    // Gapped input plus a start pulse while busy
    clr_mon();
    start_job(16'h0010, 16'd8);
    for (int i = 1; i <= 8; i++) begin
      repeat ($urandom_range(0, 3)) begin
        in_data = 8'($urandom);
        idle(1);
      end
      push_byte(8'(i), acc[i]);
      if (i == 3) begin
        start_job(16'h0080, 16'd4);
      end
    end
    idle(8);
    chk("gap_nwr", wa_q.size(), 2);
    chk("gap_a0", wa_q[0], 16'h0010);
    chk("gap_d0", wd_q[0], 32'h04030201);
    chk("gap_a1", wa_q[1], 16'h0014);
    chk("gap_d1", wd_q[1], 32'h08070605);
    chk("gap_ndone", dc_q.size(), 1);

    // Abort after two bytes, then a fresh job
    clr_mon();
    start_job(16'h0050, 16'd8);
    push_byte(8'h11, a4);
    push_byte(8'h22, a4);
    cfg_abort = 1'b1;
    idle(1);
    cfg_abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    @(posedge clk); #1;
    idle(4);
    chk("abort_nwr", wa_q.size(), 0);
    chk("abort_ndone", dc_q.size(), 0);
    clr_mon();
    start_job(16'h0040, 16'd4);
    push_byte(8'hAA, a4); push_byte(8'hBB, a4); push_byte(8'hCC, a4); push_byte(8'hDD, a8);
    idle(5);
    chk("post_abort_nwr", wa_q.size(), 1);
    chk("post_abort_a", wa_q[0], 16'h0040);
    chk("post_abort_d", wd_q[0], 32'hDDCCBBAA);
    chk("post_abort_done", dc_q.size(), 1);

    // Reset after two bytes, then a fresh job
    clr_mon();
    start_job(16'h0060, 16'd8);
    push_byte(8'h33, a4);
    push_byte(8'h44, a4);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_addr", ex_addr, 0);
    chk("mrst_data", ex_wrt_data, 0);
    @(posedge clk); #1;
    idle(4);
    chk("mrst_nwr", wa_q.size(), 0);
    chk("mrst_ndone", dc_q.size(), 0);
    clr_mon();
    start_job(16'h0040, 16'd4);
    push_byte(8'hAA, a4); push_byte(8'hBB, a4); push_byte(8'hCC, a4); push_byte(8'hDD, a8);
    idle(5);
    chk("post_rst_nwr", wa_q.size(), 1);
    chk("post_rst_a", wa_q[0], 16'h0040);
    chk("post_rst_d", wd_q[0], 32'hDDCCBBAA);
    chk("post_rst_lat", wc_q[0], a8 + 1);
    chk("post_rst_done", dc_q[0], a8 + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_dma_loader.md
EX_DMA_LOADER -- requirements
Module: ex_dma_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, giving the data memory byte-address width.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the job byte-count width.
REQ-003 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port cfg_start, input, 1: job start pulse, sampled only in IDLE.
REQ-006 Port cfg_abort, input, 1: cancel the current job.
REQ-007 Port cfg_base_addr, input, ADDR_W: job start byte address; must be 4-byte aligned.
REQ-008 Port cfg_byte_cnt, input, CNT_W: job length in bytes.
REQ-009 Port in_valid, input, 1: host byte valid.
REQ-010 Port in_data, input, 8: host byte.
REQ-011 Port in_ready, output, 1: block accepts in_data this cycle.
REQ-012 Port ex_addr, output, ADDR_W: data memory external-port byte address.
REQ-013 Port ex_wrt_data, output, 32: data memory external-port write word.
REQ-014 Port ex_wrt_en, output, 1: data memory external-port write strobe.
REQ-015 Port busy, output, 1: job in progress.
REQ-016 Port done, output, 1: one-cycle pulse at job completion.
REQ-017 Port err, output, 1: one-cycle pulse on a rejected start.

Function
REQ-018 The FSM SHALL have states IDLE, PACK, WRITE and DONE.
REQ-019 The byte transfer SHALL occur on a cycle with in_valid and in_ready both high.
REQ-020 In IDLE, cfg_start with cfg_base_addr[1:0] != 0 SHALL pulse err the next cycle, stay in IDLE and latch nothing.
REQ-021 In IDLE, an aligned cfg_start with cfg_byte_cnt == 0 SHALL pulse done the next cycle, stay in IDLE and produce no write.
REQ-022 In IDLE, an aligned cfg_start with cfg_byte_cnt != 0 SHALL latch the address and count, clear the packer and enter PACK.
REQ-023 cfg_start outside IDLE SHALL be ignored.
REQ-024 in_ready SHALL be high only in PACK; busy SHALL be high in PACK and WRITE.
REQ-025 In PACK, the k-th accepted byte of a word (k = 0..3) SHALL go to lane bits [8k+7:8k], little-endian, and decrement the remaining count by 1.
REQ-026 PACK SHALL move to WRITE on the cycle lane 3 is filled or the remaining count reaches 0; unfilled lanes SHALL be zero.
REQ-027 WRITE SHALL last exactly one cycle, with registered ex_wrt_en = 1, ex_addr = current address and ex_wrt_data = the packed word.
REQ-028 On leaving WRITE, the current address SHALL advance by 4 modulo 2^ADDR_W (0xFFFC wraps to 0x0000) and the packer SHALL clear.
REQ-029 From WRITE, the FSM SHALL enter DONE if the remaining count is 0, otherwise PACK.
REQ-030 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-031 Latency SHALL be: last byte of a word accepted in cycle N, ex_wrt_en high in N+1; for the final word, done high in N+2.
REQ-032 Outside WRITE, ex_wrt_en SHALL be 0, and ex_addr and ex_wrt_data SHALL hold their last values.
REQ-033 cfg_abort in PACK or WRITE SHALL return the FSM to IDLE the next cycle, discard the partial word, assert no done, and not suppress a write already driven that cycle.
REQ-034 in_valid gaps SHALL stall packing without loss; in_data SHALL be ignored while in_ready = 0.

Reset
REQ-035 rst SHALL force state IDLE and in_ready, ex_wrt_en, busy, done and err to 0.
REQ-036 rst SHALL force ex_addr, ex_wrt_data, the address/count registers and the packer to 0.
REQ-037 rst mid-job SHALL discard the job with no further write; the next job SHALL run normally.

Verification
REQ-038 base 0x0010, cnt 8, bytes 01..08 back-to-back -> writes 0x04030201@0x0010 then 0x08070605@0x0014, one done pulse, 2 writes total.
REQ-039 base 0x0020, cnt 6, bytes 01..06 -> 0x04030201@0x0020, 0x00000605@0x0024, done 1 cycle after the second write.
REQ-040 base 0xFFFC, cnt 8 -> second write at 0x0000.
REQ-041 base 0x0002, cnt 4 -> err pulse, busy stays 0, no ex_wrt_en; cnt 0 aligned -> done pulse, no write.
REQ-042 Random in_valid gaps plus cfg_start asserted while busy -> word sequence identical to the gap-free run; second start ignored.
REQ-043 rst (or cfg_abort) after 2 bytes of a word -> no write, no done; a following job base 0x0040, cnt 4, bytes AA BB CC DD -> 0xDDCCBBAA@0x0040.
